// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
// Bundle of button signals between the raw push-button pins and the
// conditioned event outputs.
//   btn_in      : raw asynchronous button inputs (active-high)
//   btn_level   : debounced level per channel
//   btn_press   : one-cycle pulse on a debounced rising edge
//   btn_release : one-cycle pulse on a debounced falling edge
//   btn_repeat  : one-cycle auto-repeat pulse while held
//   selected    : latched program number (0 = none)
//   sel_change  : one-cycle pulse when selected is written
// modport master : drives btn_in, observes everything else (board/testbench)
// modport slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
  parameter int NCH   = 5,
  parameter int SEL_W = 32
);
  logic [NCH-1:0]   btn_in;
  logic [NCH-1:0]   btn_level;
  logic [NCH-1:0]   btn_press;
  logic [NCH-1:0]   btn_release;
  logic [NCH-1:0]   btn_repeat;
  logic [SEL_W-1:0] selected;
  logic             sel_change;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_repeat, selected, sel_change
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_repeat, selected, sel_change
  );
endinterface

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// N-channel push-button front end: 2-flop synchroniser, counter debouncer,
// registered press/release pulses, optional auto-repeat, and a latched
// program selector driven by presses on the masked channels.
// Ports:
//   clock : system clock, all state on posedge
//   reset : synchronous, active-high; clears every register
//   bus   : button_conditioner_if.slave (btn_in in; levels/pulses/selector out)
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int             NCH           = 5,
  parameter int             DELAY         = 250000,
  parameter int             REPEAT_START  = 0,
  parameter int             REPEAT_PERIOD = 125000,
  parameter logic [NCH-1:0] SEL_MASK      = 5'b00110,
  parameter int             SEL_W         = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  button_conditioner_if.slave   bus
);

  localparam int CW   = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int RMAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [NCH-1:0]   s1_q, s2_q;
  logic [NCH-1:0]   level_q, level_d;
  logic [NCH-1:0]   press_q, release_q;
  logic [NCH-1:0]   repeat_q, repeat_d;
  logic [SEL_W-1:0] selected_q, selected_d;
  logic             sel_change_q, sel_change_d;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d;
      logic          lvl_d;

      // Counter tracks consecutive cycles the synchronised input disagrees
      // with the debounced level; any agreement restarts the count.
      always_comb begin
        cnt_d = '0;
        lvl_d = level_q[gi];
        if (s2_q[gi] != level_q[gi]) begin
          if (cnt_q == CW'(DELAY - 1)) begin
            lvl_d = s2_q[gi];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign level_d[gi] = lvl_d;

      if (REPEAT_START > 0) begin : g_rep
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic [RW-1:0] inc;
        logic [RW-1:0] target;
        logic          started_q, started_d;
        logic          fire;

        // rcnt counts cycles since the press (or since the last repeat);
        // the first interval is REPEAT_START, later ones REPEAT_PERIOD.
        always_comb begin
          rcnt_d    = '0;
          started_d = 1'b0;
          fire      = 1'b0;
          inc       = (press_q[gi] ? '0 : rcnt_q) + RW'(1);
          target    = (started_q && !press_q[gi]) ? RW'(REPEAT_PERIOD) : RW'(REPEAT_START);
          if (level_q[gi]) begin
            if (inc == target) begin
              fire      = 1'b1;
              started_d = 1'b1;
            end else begin
              rcnt_d    = inc;
              started_d = started_q && !press_q[gi];
            end
          end
        end

        always_ff @(posedge clock) begin
          if (reset) begin
            rcnt_q    <= '0;
            started_q <= 1'b0;
          end else begin
            rcnt_q    <= rcnt_d;
            started_q <= started_d;
          end
        end

        // Suppress a repeat that would land on the release cycle.
        assign repeat_d[gi] = fire & lvl_d;
      end else begin : g_norep
        assign repeat_d[gi] = 1'b0;
      end
    end
  endgenerate

  // Lowest-index masked press wins; loop runs high-to-low so the last
  // assignment is the lowest channel.
  always_comb begin
    selected_d   = selected_q;
    sel_change_d = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (press_q[k] && SEL_MASK[k]) begin
        selected_d   = SEL_W'(k + 1);
        sel_change_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      level_q      <= '0;
      press_q      <= '0;
      release_q    <= '0;
      repeat_q     <= '0;
      selected_q   <= '0;
      sel_change_q <= 1'b0;
    end else begin
      s1_q         <= bus.btn_in;
      s2_q         <= s1_q;
      level_q      <= level_d;
      press_q      <= level_d & ~level_q;
      release_q    <= ~level_d & level_q;
      repeat_q     <= repeat_d;
      selected_q   <= selected_d;
      sel_change_q <= sel_change_d;
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_repeat  = repeat_q;
  assign bus.selected    = selected_q;
  assign bus.sel_change  = sel_change_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Directed scenarios with hand-computed expectations, followed by random
// button activity with occasional resets. A behavioural model (sample
// history window, press timestamps) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_button_conditioner;
  localparam int             NCH  = 5;
  localparam int             DLY  = 4;
  localparam int             RS   = 6;
  localparam int             RP   = 3;
  localparam logic [NCH-1:0] MASK = 5'b00110;
  localparam int             SW   = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  button_conditioner_if #(.NCH(NCH), .SEL_W(SW)) bus ();

  button_conditioner #(
    .NCH(NCH), .DELAY(DLY), .REPEAT_START(RS), .REPEAT_PERIOD(RP),
    .SEL_MASK(MASK), .SEL_W(SW)
  ) dut (
    .clock(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [NCH-1:0] samp_q[$];
  logic [NCH-1:0] vwin[$];
  logic [NCH-1:0] exp_level, exp_press, exp_release, exp_repeat;
  logic [SW-1:0]  exp_sel;
  logic           exp_chg;
  logic           model_valid = 1'b0;
  int             t_now;
  int             press_t[NCH];
  logic [NCH-1:0] m_v, m_nl, m_old_press;
  logic           m_diff;
  int             m_d;

  always @(posedge clk) begin
    if (reset) begin
      samp_q.delete();
      vwin.delete();
      exp_level = '0; exp_press = '0; exp_release = '0; exp_repeat = '0;
      exp_sel = '0; exp_chg = 1'b0;
      t_now = 0;
      model_valid = 1'b1;
    end else begin
      t_now++;
      // Debouncer sees the input sampled two edges earlier.
      m_v = (samp_q.size() == 2) ? samp_q[0] : '0;
      samp_q.push_back(bus.btn_in);
      if (samp_q.size() > 2) void'(samp_q.pop_front());
      vwin.push_back(m_v);
      if (vwin.size() > DLY) void'(vwin.pop_front());
      // Level flips once DELAY consecutive synchronised samples disagree.
      m_nl = exp_level;
      if (vwin.size() == DLY) begin
        for (int c = 0; c < NCH; c++) begin
          m_diff = 1'b1;
          for (int j = 0; j < DLY; j++)
            if (vwin[j][c] == exp_level[c]) m_diff = 1'b0;
          if (m_diff) m_nl[c] = ~exp_level[c];
        end
      end
      m_old_press = exp_press;
      exp_press   = m_nl & ~exp_level;
      exp_release = ~m_nl & exp_level;
      for (int c = 0; c < NCH; c++) begin
        exp_repeat[c] = 1'b0;
        if (exp_press[c]) press_t[c] = t_now;
        else if (m_nl[c] && exp_level[c]) begin
          m_d = t_now - press_t[c];
          if (m_d >= RS && ((m_d - RS) % RP) == 0) exp_repeat[c] = 1'b1;
        end
      end
      exp_chg = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
        if (m_old_press[k] && MASK[k]) begin
          exp_sel = SW'(k + 1);
          exp_chg = 1'b1;
        end
      end
      exp_level = m_nl;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      check("level",      64'(bus.btn_level),   64'(exp_level));
      check("press",      64'(bus.btn_press),   64'(exp_press));
      check("release",    64'(bus.btn_release), 64'(exp_release));
      check("repeat",     64'(bus.btn_repeat),  64'(exp_repeat));
      check("selected",   64'(bus.selected),    64'(exp_sel));
      check("sel_change", 64'(bus.sel_change),  64'(exp_chg));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int hold[NCH];

  initial begin
    bus.btn_in = '0;
    reset = 1'b1;
    step(3);
    check("rst_level", 64'(bus.btn_level), 64'd0);
    check("rst_sel",   64'(bus.selected),  64'd0);
    reset = 1'b0;
    step(2);

    // Clean press on channel 1
    bus.btn_in[1] = 1'b1;
    step(5);
    check("clean_level_early", 64'(bus.btn_level[1]), 64'd0);
    step(1);
    check("clean_level", 64'(bus.btn_level[1]), 64'd1);
    check("clean_press", 64'(bus.btn_press[1]), 64'd1);
    step(1);
    check("clean_press_1cyc", 64'(bus.btn_press[1]), 64'd0);
    check("clean_sel",        64'(bus.selected),     64'd2);
    check("clean_chg",        64'(bus.sel_change),   64'd1);
    step(1);
    check("clean_chg_1cyc", 64'(bus.sel_change), 64'd0);
    bus.btn_in[1] = 1'b0;
    step(8);

    // Glitch rejection on channel 2
    bus.btn_in[2] = 1'b1;
    step(3);
    bus.btn_in[2] = 1'b0;
    step(10);
    check("glitch_level", 64'(bus.btn_level[2]), 64'd0);
    check("glitch_sel",   64'(bus.selected),     64'd2);
    bus.btn_in[2] = 1'b1; step(1);
    bus.btn_in[2] = 1'b0; step(1);
    bus.btn_in[2] = 1'b1;
    step(5);
    check("bounce_press_early", 64'(bus.btn_press[2]), 64'd0);
    step(1);
    check("bounce_press", 64'(bus.btn_press[2]), 64'd1);
    step(1);
    check("bounce_sel", 64'(bus.selected), 64'd3);
    bus.btn_in[2] = 1'b0;
    step(8);

    // Auto-repeat on unmasked channel 3
    bus.btn_in[3] = 1'b1;
    step(6);
    check("rep_press", 64'(bus.btn_press[3]), 64'd1);
    step(5);
    check("rep_early", 64'(bus.btn_repeat[3]), 64'd0);
    step(1);
    check("rep_first", 64'(bus.btn_repeat[3]), 64'd1);
    step(1);
    check("rep_gap", 64'(bus.btn_repeat[3]), 64'd0);
    step(2);
    check("rep_second", 64'(bus.btn_repeat[3]), 64'd1);
    check("rep_sel",    64'(bus.selected),      64'd3);
    bus.btn_in[3] = 1'b0;
    step(6);
    check("rep_release",    64'(bus.btn_release[3]), 64'd1);
    check("rep_no_repeat",  64'(bus.btn_repeat[3]),  64'd0);
    step(4);

    // Simultaneous press on channels 1 and 2
    bus.btn_in[2:1] = 2'b11;
    step(6);
    check("simul_press", 64'(bus.btn_press), 64'b00110);
    step(1);
    check("simul_sel", 64'(bus.selected), 64'd2);
    bus.btn_in[2:1] = 2'b00;
    step(8);

    // Reset while channel 2 held and selected=3
    bus.btn_in[2] = 1'b1;
    step(7);
    check("pre_rst_sel", 64'(bus.selected), 64'd3);
    reset = 1'b1;
    step(1);
    check("mid_rst_level", 64'(bus.btn_level), 64'd0);
    check("mid_rst_sel",   64'(bus.selected),  64'd0);
    step(1);
    reset = 1'b0;
    step(5);
    check("post_rst_press_early", 64'(bus.btn_press[2]), 64'd0);
    step(1);
    check("post_rst_press",   64'(bus.btn_press[2]),   64'd1);
    check("post_rst_release", 64'(bus.btn_release[2]), 64'd0);
    step(1);
    check("post_rst_sel", 64'(bus.selected), 64'd3);
    bus.btn_in[2] = 1'b0;
    step(8);

    // Unmasked press on channel 0
    bus.btn_in[0] = 1'b1;
    step(6);
    check("nm_press", 64'(bus.btn_press[0]), 64'd1);
    step(1);
    check("nm_chg", 64'(bus.sel_change), 64'd0);
    check("nm_sel", 64'(bus.selected),   64'd3);
    bus.btn_in[0] = 1'b0;
    step(8);

    // Random activity: each channel holds a value for a random run length
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          bus.btn_in[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 14);
        end else begin
          hold[c]--;
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised N-channel front end for the labkit push-buttons. Replaces the per-button debounce instances and the ad-hoc program_selector register in the top level.
- Per channel it provides a 2-flop synchroniser, a counter debouncer, one-cycle press and release pulses, and optional auto-repeat.
- A latched program selector is derived from masked press events. It feeds the register file's program-select input and holds its value after the button is released.

Parameters:
- NCH, 5, number of button channels.
- DELAY, 250000, cycles of stable synchronised input required to change the debounced level (10 ms at 25 MHz); must be ≥2.
- REPEAT_START, 0, cycles a level must stay high before the first repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 125000, cycles between subsequent repeat pulses; must be ≥1.
- SEL_MASK, 5'b00110, bit i=1 means channel i participates in program selection.
- SEL_W, 32, width of the selected output.

Ports:
- clock  in  1  25 MHz system clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- btn_in  in  NCH  raw asynchronous button inputs, active-high.
- btn_level  out  NCH  debounced level.
- btn_press  out  NCH  one-cycle pulse on a debounced rising edge.
- btn_release  out  NCH  one-cycle pulse on a debounced falling edge.
- btn_repeat  out  NCH  one-cycle auto-repeat pulse while held.
- selected  out  SEL_W  latched program number; 0 = none.
- sel_change  out  1  one-cycle pulse when selected is updated.

Behaviour:
- Reset: while reset=1 at a clock edge, all of the following clear to 0: synchroniser flops, debounce counters, repeat counters, btn_level, btn_press, btn_release, btn_repeat, selected, sel_change. Reset overrides every event in the same cycle.
- Synchroniser: s2[i] is btn_in[i] delayed two clocks.
- Debounce, per channel:
  - When s2 equals btn_level, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter reaches DELAY-1 while s2 still differs, btn_level takes the value of s2 and the counter is cleared.
  - Latency: a clean input edge reaches btn_level on the (DELAY+2)th rising edge after btn_in is first sampled at its new value.
  - Any pulse or glitch shorter than DELAY synchronised cycles is fully rejected and produces no output change.
- Counter width: clog2(DELAY). The counter never wraps, because it clears at DELAY-1.
- Edge pulses are registered. btn_press[i] is 1 in exactly the cycle btn_level[i] first reads 1. btn_release[i] is 1 in exactly the cycle btn_level[i] first reads 0. Each lasts one cycle.
- Auto-repeat (only when REPEAT_START>0):
  - The repeat counter clears on btn_press and whenever btn_level=0.
  - The first btn_repeat fires REPEAT_START cycles after the btn_press cycle.
  - Further pulses fire every REPEAT_PERIOD cycles while btn_level stays 1.
  - Release stops repeat immediately; no btn_repeat in the btn_release cycle.
  - btn_repeat is never asserted in the same cycle as btn_press.
- Selector:
  - One cycle after a btn_press on any masked channel, selected <= k+1, where k is the lowest-index masked channel pressing in that cycle. sel_change=1 in that same cycle.
  - Presses on unmasked channels, btn_repeat, and btn_release do not affect selected.
  - Re-pressing the already-selected channel rewrites the same value and still pulses sel_change.
  - selected holds indefinitely until the next masked press or reset.
- Simultaneous presses: every btn_press bit fires independently. The selector applies lowest-index priority.
- Reset mid-operation:
  - A debounce in progress is discarded.
  - A button held through reset deassertion is treated as a new press: btn_level rises DELAY+2 cycles after reset falls, with btn_press, and a selector update if the channel is masked.
  - A button held through reset produces no btn_release.

Test Plan:
- Bench configuration: DELAY=4, REPEAT_START=6, REPEAT_PERIOD=3, NCH=5, SEL_MASK=5'b00110.
- Clean press: btn_in[1] 0->1 and held -> btn_level[1]=1 and btn_press[1]=1 on the 6th edge after the input is sampled high; press is 1 for one cycle only. One cycle later selected=2 and sel_change=1.
- Glitch rejection: btn_in[2] high for 3 cycles, then low -> btn_level, btn_press and selected unchanged. Then a bounce pattern 1,0,1 followed by a steady 1 -> exactly one btn_press[2], issued 6 edges after the last 0->1 sample.
- Auto-repeat: hold btn_in[3] high -> btn_repeat[3] pulses 6, 9, 12 … cycles after btn_press[3]. Releasing produces btn_release[3] after the debounce delay and no further repeats. selected stays at its prior value, since channel 3 is unmasked.
- Simultaneous: btn_in[1] and btn_in[2] rise in the same cycle -> both press bits pulse together; selected=2.
- Reset mid-operation: assert reset while btn_in[2] is held and selected=3 -> all outputs read 0 on the next edge. Deassert reset with the button still held -> btn_press[2] fires 6 edges later, then selected=3; no btn_release is seen.
- Non-masked press: btn_in[0] pressed -> btn_press[0] pulses, selected unchanged, sel_change stays 0.
